sprite_multicolour: RTL and testbench
=====================================

Name: sprite_multicolour

Overview:
- Next-generation sprite engine for the HDMI overlay. Draws one WIDTH x HEIGHT sprite at an arbitrary signed screen position.
- Pixels are COLRW-bit colour indices, not 1-bit.
- Scale factors and horizontal/vertical flip are runtime inputs latched at start.
- Sits between the sprite graphics ROM/BRAM (line-wide read port, arbitrated by dma_avail) and the palette/compositor stage. One instance per sprite per scanline pass.

Parameters:
- WIDTH, 8: sprite width in pixels (power of two, 2..64).
- HEIGHT, 8: sprite height in lines (power of two, 2..64).
- COLRW, 4: bits per pixel (colour index width, 1..8).
- SCALEW, 4: width of scale_x/scale_y inputs.
- LSB, 1: 1 = pixel 0 in data_in[COLRW-1:0]; 0 = pixel 0 in the most significant COLRW bits.
- CORDW, 16: signed screen coordinate width.
- ADDRW, 9: graphic memory address width.
- TRANSP, 0: colour index treated as transparent (used only with the optional feature).

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: synchronous reset, active low.
- start, input, 1: begin sprite (sampled in IDLE only).
- dma_avail, input, 1: memory read slot granted this cycle.
- flip_x, input, 1: mirror horizontally (latched on start).
- flip_y, input, 1: mirror vertically (latched on start).
- scale_x, input, SCALEW: horizontal scale; 0 treated as 1 (latched on start).
- scale_y, input, SCALEW: vertical scale; 0 treated as 1 (latched on start).
- base_addr, input, ADDRW: address of sprite line 0 (latched on start).
- sx, input, CORDW signed: current horizontal screen position.
- sprx, input, CORDW signed: sprite horizontal position.
- data_in, input, WIDTH*COLRW: sprite line from memory, valid one cycle after address.
- addr, output, ADDRW: memory line address.
- pix, output, COLRW: colour index; 0 when not drawing.
- pix_opaque, output, 1: pixel is to be composited.
- drawing, output, 1: high in DRAW state.
- done, output, 1: sprite complete; held until next start.

Behaviour:
- Reset (rst_n=0 at clk edge, any state, overrides all):
  - state=IDLE; addr=0, done=0, drawing=0, pix=0, pix_opaque=0.
  - Internal line register, offsets and counters cleared.
  - An in-progress sprite is abandoned; done is not asserted.
- States:
  - IDLE: start -> START.
  - START (1 cycle): latch inputs; clear done; oy=0, cnt_y=0; addr = base_addr + (flip_y ? HEIGHT-1 : 0). -> AWAIT_DMA.
  - AWAIT_DMA: dma_avail -> READ_MEM.
  - READ_MEM (1 cycle): register data_in into the line buffer, unpacked to WIDTH entries of COLRW bits (reordered when LSB=0). -> AWAIT_POS.
  - AWAIT_POS: ox=0, cnt_x=0. When sx == sprx-2 (signed compare, CORDW wrap) -> DRAW. The first DRAW cycle therefore coincides with sx == sprx-1; the compositor's output register aligns it to sprx.
  - DRAW: pix = line[flip_x ? WIDTH-1-ox : ox]. cnt_x counts 0..sx_eff-1, where sx_eff = max(scale_x,1); at wrap, ox increments.
    - last_pixel = (ox==WIDTH-1 && cnt_x==sx_eff-1).
    - On last_pixel: -> DONE if last_line, else -> NEXT_LINE.
  - NEXT_LINE (1 cycle): if cnt_y==sy_eff-1: cnt_y=0, oy+1, addr +1 (or -1 when flip_y), -> AWAIT_DMA (refetch). Else cnt_y+1, -> AWAIT_POS (reuse buffered line).
  - last_line = (oy==HEIGHT-1 && cnt_y==sy_eff-1).
  - DONE (1 cycle): done<=1. -> IDLE.
- Timing and signalling:
  - Total drawn width = WIDTH*sx_eff cycles per line; HEIGHT*sy_eff line passes per sprite.
  - drawing and pix are combinational from state, offsets and the line buffer. pix_opaque = drawing unless the optional feature is enabled.
  - start while not in IDLE is ignored. start in the same cycle as DONE is ignored (the sprite is taken the cycle after, from IDLE).
  - Changes to the latched inputs (flip_x, flip_y, scale_x, scale_y, base_addr) mid-sprite have no effect.
  - addr arithmetic is modulo 2^ADDRW.
  - Counters are SCALEW bits; ox/oy are $clog2 of WIDTH/HEIGHT.

Optional Feature:
- Macro: SPRITE_MULTICOLOUR_TRANSP_EN.
- Defined: pix_opaque = drawing && (pix != TRANSP). pix still outputs the raw index.
- Undefined: pix_opaque = drawing. TRANSP is unused.

Test Plan:
- WIDTH=8, HEIGHT=8, COLRW=4, scale 1/1, sprx=100, line 0 = 0x76543210, dma_avail=1 -> DRAW first seen at sx=99; pix = 0,1,..,7 over 8 cycles; 8 fetches at addr base..base+7; done pulses then holds.
- Same data with flip_x=1 -> pix = 7,6,..,0. With flip_y=1, base=16 -> addr sequence 23,22,..,16.
- scale_x=3, scale_y=2 -> each pixel held 3 cycles (24 DRAW cycles per line); each address fetched once with 2 DRAW passes per line; 16 passes total. scale_x=0 behaves as 1.
- dma_avail held low for 5 cycles in AWAIT_DMA -> no READ_MEM and no DRAW; drawing resumes correctly once granted; addr stable while waiting.
- rst_n=0 for one cycle mid-DRAW -> next cycle state IDLE; pix=0, drawing=0, done=0, addr=0; a following start draws the full sprite from line 0.
- Macro defined, TRANSP=0, line = 0x00F0000F -> pix_opaque high only for pixel 0 and pixel 5; macro undefined -> pix_opaque high for all 8.

Source files
------------

// File: rtl/sprite_multicolour.sv
// Multicolour sprite line engine: fetches sprite lines, scales/flips them and streams colour indices.
// Optional transparency keying is enabled with `define SPRITE_MULTICOLOUR_TRANSP_EN.
module sprite_multicolour #(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8,
    parameter int COLRW  = 4,
    parameter int SCALEW = 4,
    parameter int LSB    = 1,
    parameter int CORDW  = 16,
    parameter int ADDRW  = 9,
    parameter int TRANSP = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     dma_avail,
    input  logic                     flip_x,
    input  logic                     flip_y,
    input  logic [SCALEW-1:0]        scale_x,
    input  logic [SCALEW-1:0]        scale_y,
    input  logic [ADDRW-1:0]         base_addr,
    input  logic signed [CORDW-1:0]  sx,
    input  logic signed [CORDW-1:0]  sprx,
    input  logic [WIDTH*COLRW-1:0]   data_in,
    output logic [ADDRW-1:0]         addr,
    output logic [COLRW-1:0]         pix,
    output logic                     pix_opaque,
    output logic                     drawing,
    output logic                     done
);
    localparam int OXW = $clog2(WIDTH);
    localparam int OYW = $clog2(HEIGHT);

    // state     | meaning
    // IDLE      | waiting for start
    // START     | latch controls, set first line address
    // AWAIT_DMA | waiting for a memory read slot
    // READ_MEM  | capture data_in into the line buffer
    // AWAIT_POS | waiting for the beam to reach sprx-2
    // DRAW      | streaming pixels of the buffered line
    // NEXT_LINE | advance vertical repeat / line address
    // DONE      | raise done, return to IDLE
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_AWAIT_DMA, S_READ_MEM,
        S_AWAIT_POS, S_DRAW, S_NEXT_LINE, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDRW-1:0]    addr_q, addr_d;
    logic                done_q, done_d;
    logic                fx_q, fx_d, fy_q, fy_d;
    logic [SCALEW-1:0]   scx_q, scx_d, scy_q, scy_d;
    logic [SCALEW-1:0]   cnt_x_q, cnt_x_d, cnt_y_q, cnt_y_d;
    logic [OXW-1:0]      ox_q, ox_d;
    logic [OYW-1:0]      oy_q, oy_d;
    logic [COLRW-1:0]    line_q [WIDTH];
    logic [COLRW-1:0]    line_d [WIDTH];

    logic [SCALEW-1:0]       sx_eff, sy_eff;
    logic                    last_pixel, last_line;
    logic signed [CORDW-1:0] trig_x;
    logic [OXW-1:0]          pix_idx;

    always_comb begin
        sx_eff     = (scx_q == '0) ? SCALEW'(1) : scx_q;
        sy_eff     = (scy_q == '0) ? SCALEW'(1) : scy_q;
        last_pixel = (ox_q == OXW'(WIDTH - 1)) && (cnt_x_q == sx_eff - SCALEW'(1));
        last_line  = (oy_q == OYW'(HEIGHT - 1)) && (cnt_y_q == sy_eff - SCALEW'(1));
        trig_x     = sprx - CORDW'(2);
        pix_idx    = fx_q ? (OXW'(WIDTH - 1) - ox_q) : ox_q;
        drawing    = (state_q == S_DRAW);
        pix        = drawing ? line_q[pix_idx] : '0;
`ifdef SPRITE_MULTICOLOUR_TRANSP_EN
        pix_opaque = drawing && (pix != COLRW'(TRANSP));
`else
        pix_opaque = drawing;
`endif
        addr       = addr_q;
        done       = done_q;
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        done_d  = done_q;
        fx_d    = fx_q;
        fy_d    = fy_q;
        scx_d   = scx_q;
        scy_d   = scy_q;
        cnt_x_d = cnt_x_q;
        cnt_y_d = cnt_y_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        for (int i = 0; i < WIDTH; i++) line_d[i] = line_q[i];

        case (state_q)
            S_IDLE: if (start) state_d = S_START;
            S_START: begin
                fx_d    = flip_x;
                fy_d    = flip_y;
                scx_d   = scale_x;
                scy_d   = scale_y;
                done_d  = 1'b0;
                oy_d    = '0;
                cnt_y_d = '0;
                addr_d  = base_addr + (flip_y ? ADDRW'(HEIGHT - 1) : '0);
                state_d = S_AWAIT_DMA;
            end
            S_AWAIT_DMA: if (dma_avail) state_d = S_READ_MEM;
            S_READ_MEM: begin
                // LSB=0 packs pixel 0 in the top bits, so reverse while unpacking
                for (int i = 0; i < WIDTH; i++) begin
                    if (LSB != 0) line_d[i] = data_in[i*COLRW +: COLRW];
                    else          line_d[i] = data_in[(WIDTH-1-i)*COLRW +: COLRW];
                end
                state_d = S_AWAIT_POS;
            end
            S_AWAIT_POS: begin
                ox_d    = '0;
                cnt_x_d = '0;
                if (sx == trig_x) state_d = S_DRAW;
            end
            S_DRAW: begin
                if (cnt_x_q == sx_eff - SCALEW'(1)) begin
                    cnt_x_d = '0;
                    ox_d    = ox_q + OXW'(1);
                end else begin
                    cnt_x_d = cnt_x_q + SCALEW'(1);
                end
                if (last_pixel) state_d = last_line ? S_DONE : S_NEXT_LINE;
            end
            S_NEXT_LINE: begin
                if (cnt_y_q == sy_eff - SCALEW'(1)) begin
                    cnt_y_d = '0;
                    oy_d    = oy_q + OYW'(1);
                    addr_d  = fy_q ? (addr_q - ADDRW'(1)) : (addr_q + ADDRW'(1));
                    state_d = S_AWAIT_DMA;
                end else begin
                    cnt_y_d = cnt_y_q + SCALEW'(1);
                    state_d = S_AWAIT_POS;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            done_q  <= 1'b0;
            fx_q    <= 1'b0;
            fy_q    <= 1'b0;
            scx_q   <= '0;
            scy_q   <= '0;
            cnt_x_q <= '0;
            cnt_y_q <= '0;
            ox_q    <= '0;
            oy_q    <= '0;
            for (int i = 0; i < WIDTH; i++) line_q[i] <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
            fx_q    <= fx_d;
            fy_q    <= fy_d;
            scx_q   <= scx_d;
            scy_q   <= scy_d;
            cnt_x_q <= cnt_x_d;
            cnt_y_q <= cnt_y_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            for (int i = 0; i < WIDTH; i++) line_q[i] <= line_d[i];
        end
    end
endmodule

// File: tb/tb_sprite_multicolour.sv
// Bench for sprite_multicolour: pixel-stream model built from sprite memory, flip and scale rules.
module tb_sprite_multicolour;
    localparam int W = 8, H = 8, CW = 4, AW = 9;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, dma_avail = 1'b0;
    logic flip_x = 1'b0, flip_y = 1'b0;
    logic [3:0] scale_x = 4'd1, scale_y = 4'd1;
    logic [AW-1:0] base_addr = '0;
    logic signed [15:0] sx = -16'sd32, sprx = 16'sd0;
    logic [W*CW-1:0] data_in = '0;
    logic [AW-1:0] addr;
    logic [CW-1:0] pix;
    logic pix_opaque, drawing, done;

    sprite_multicolour dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dma_avail(dma_avail),
        .flip_x(flip_x), .flip_y(flip_y), .scale_x(scale_x), .scale_y(scale_y),
        .base_addr(base_addr), .sx(sx), .sprx(sprx), .data_in(data_in),
        .addr(addr), .pix(pix), .pix_opaque(pix_opaque), .drawing(drawing), .done(done)
    );

    always #5 clk = ~clk;

    logic [W*CW-1:0] mem [1 << AW];
    int total = 0, bad = 0;
    int cyc = 0, dma_pct = 100;

    int exp_pix[$], exp_addr[$];
    int obs_pix[$], obs_addr[$];
    int pass_cnt, first_len, first_opaque, first_sx, last_pix_cyc;
    logic drawing_prev = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    // memory, beam position and DMA grant stimulus
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            sx = (sx == 16'sd127) ? -16'sd32 : sx + 16'sd1;
            data_in = mem[addr];
            dma_avail = (int'($urandom_range(99)) < dma_pct);
        end
    end

    always @(negedge clk) begin
        int e;
        if (drawing) begin
            if (!drawing_prev) begin
                pass_cnt++;
                if (exp_addr.size() == 0) chk("pass_extra", 1, 0);
                else chk("pass_addr", int'(addr), exp_addr.pop_front());
                chk("pass_sx", int'(sx), int'(sprx) - 1);
                obs_addr.push_back(int'(addr));
                if (pass_cnt == 1) first_sx = int'(sx);
            end
            chk("done_low_draw", int'(done), 0);
            if (exp_pix.size() == 0) begin
                chk("pix_extra", 1, 0);
            end else begin
                e = exp_pix.pop_front();
                chk("pix", int'(pix), e);
`ifdef SPRITE_MULTICOLOUR_TRANSP_EN
                chk("opaque", int'(pix_opaque), (e != 0) ? 1 : 0);
`else
                chk("opaque", int'(pix_opaque), 1);
`endif
                if (exp_pix.size() == 0) last_pix_cyc = cyc;
            end
            if (pass_cnt == 1) begin
                first_len++;
                obs_pix.push_back(int'(pix));
                if (pix_opaque) first_opaque++;
            end
        end else begin
            chk("pix_idle", int'(pix), 0);
            chk("opaque_idle", int'(pix_opaque), 0);
        end
        drawing_prev = drawing;
    end

    task automatic build_model(input bit fx, input bit fy, input int scx, input int scy, input int base);
        int sxe, sye, row, a, v;
        logic [W*CW-1:0] ln;
        sxe = (scx == 0) ? 1 : scx;
        sye = (scy == 0) ? 1 : scy;
        exp_pix.delete(); exp_addr.delete(); obs_pix.delete(); obs_addr.delete();
        pass_cnt = 0; first_len = 0; first_opaque = 0; first_sx = -9999; last_pix_cyc = -1;
        for (int p = 0; p < H * sye; p++) begin
            row = p / sye;
            a = (base + (fy ? H - 1 - row : row)) % (1 << AW);
            exp_addr.push_back(a);
            ln = mem[a];
            for (int c = 0; c < W; c++) begin
                v = int'(ln[(fx ? W - 1 - c : c) * CW +: CW]);
                for (int k = 0; k < sxe; k++) exp_pix.push_back(v);
            end
        end
    endtask

    // called at posedge+1 phase with the DUT in IDLE; returns after START has run
    task automatic launch(input bit fx, input bit fy, input int scx, input int scy,
                          input int base, input int spx);
        build_model(fx, fy, scx, scy, base);
        flip_x = fx; flip_y = fy; scale_x = 4'(scx); scale_y = 4'(scy);
        base_addr = AW'(base); sprx = 16'(spx);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        flip_x = $urandom_range(1); flip_y = $urandom_range(1);
        scale_x = 4'($urandom_range(15)); scale_y = 4'($urandom_range(15));
        base_addr = AW'($urandom_range(511));
        chk("done_cleared", int'(done), 0);
    endtask

    task automatic finish_sprite(input string tag);
        int n = 0;
        while (!done && n < 8000) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            chk({tag, "_timeout"}, 0, 1);
        end else begin
            chk({tag, "_done_lat"}, cyc - last_pix_cyc, 2);
            chk({tag, "_pix_left"}, exp_pix.size(), 0);
            chk({tag, "_pass_left"}, exp_addr.size(), 0);
        end
        repeat (3) @(negedge clk);
        chk({tag, "_done_hold"}, int'(done), 1);
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        for (int i = 0; i < (1 << AW); i++) mem[i] = {$urandom(), $urandom()} >> 32;
        mem[40] = 32'h76543210;
        mem[80] = 32'h00F0000F;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_addr", int'(addr), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_drawing", int'(drawing), 0);
        chk("rst_pix", int'(pix), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // plain sprite
        launch(0, 0, 1, 1, 40, 100);
        finish_sprite("plain");
        chk("plain_first_sx", first_sx, 99);
        for (int i = 0; i < 8; i++) chk("plain_pix_lit", qget(obs_pix, i), i);
        chk("plain_passes", pass_cnt, 8);
        chk("plain_addr0", qget(obs_addr, 0), 40);
        chk("plain_addr7", qget(obs_addr, 7), 47);

        launch(1, 0, 1, 1, 40, 100);
        finish_sprite("flipx");
        for (int i = 0; i < 8; i++) chk("flipx_pix_lit", qget(obs_pix, i), 7 - i);

        launch(0, 1, 1, 1, 16, 20);
        finish_sprite("flipy");
        chk("flipy_addr0", qget(obs_addr, 0), 23);
        chk("flipy_addr7", qget(obs_addr, 7), 16);

        launch(0, 0, 3, 2, 60, 50);
        finish_sprite("scale32");
        chk("scale32_len", first_len, 24);
        chk("scale32_passes", pass_cnt, 16);
        chk("scale32_a0", qget(obs_addr, 0), 60);
        chk("scale32_a1", qget(obs_addr, 1), 60);
        chk("scale32_a2", qget(obs_addr, 2), 61);

        launch(0, 0, 0, 0, 40, -10);
        finish_sprite("scale0");
        chk("scale0_len", first_len, 8);
        chk("scale0_passes", pass_cnt, 8);

        // DMA starvation
        dma_pct = 0;
        launch(0, 0, 1, 1, 100, 30);
        repeat (6) @(posedge clk);
        #1;
        chk("dma_no_draw", pass_cnt, 0);
        chk("dma_addr_stable", int'(addr), 100);
        dma_pct = 100;
        finish_sprite("dma");

        // reset during DRAW
        launch(0, 0, 2, 1, 200, 60);
        n = 0;
        while (!drawing && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rst_mid_reached_draw", int'(drawing), 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_pix.delete(); exp_addr.delete();
        @(negedge clk);
        chk("rstmid_drawing", int'(drawing), 0);
        chk("rstmid_pix", int'(pix), 0);
        chk("rstmid_done", int'(done), 0);
        chk("rstmid_addr", int'(addr), 0);
        repeat (20) @(negedge clk);
        chk("rstmid_no_done", int'(done), 0);
        @(posedge clk); #1;
        launch(0, 0, 1, 1, 40, 100);
        finish_sprite("after_rst");
        for (int i = 0; i < 8; i++) chk("after_rst_pix_lit", qget(obs_pix, i), i);

        // transparency keying
        launch(0, 0, 1, 1, 80, 40);
        finish_sprite("transp");
`ifdef SPRITE_MULTICOLOUR_TRANSP_EN
        chk("transp_opaque_cnt", first_opaque, 2);
`else
        chk("transp_opaque_cnt", first_opaque, 8);
`endif

        // randomized sprites
        dma_pct = 60;
        for (int t = 0; t < 10; t++) begin
            launch($urandom_range(1), $urandom_range(1), $urandom_range(2), $urandom_range(2),
                   $urandom_range(511), int'($urandom_range(130)) - 30);
            finish_sprite("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
